// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, FSM states and
// control-field encodings.
package mc_pkg;

  localparam int OP_SIZE = 6;
  typedef logic [OP_SIZE-1:0] op_t;

  localparam op_t OP_ADD   = 6'h00;
  localparam op_t OP_SUB   = 6'h01;
  localparam op_t OP_AND   = 6'h02;
  localparam op_t OP_OR    = 6'h03;
  localparam op_t OP_ADDI  = 6'h08;
  localparam op_t OP_LOAD  = 6'h10;
  localparam op_t OP_STORE = 6'h11;
  localparam op_t OP_BEQ   = 6'h18;
  localparam op_t OP_LOADI = 6'h20;
  localparam op_t OP_JUMP  = 6'h28;
  localparam op_t OP_NOP   = 6'h3E;
  localparam op_t OP_HALT  = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;

  function automatic logic op_is_legal(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LOAD, OP_STORE,
      OP_BEQ, OP_LOADI, OP_JUMP, OP_NOP, OP_HALT: op_is_legal = 1'b1;
      default:                                   op_is_legal = 1'b0;
    endcase
  endfunction

  // Returns {aluSrcImm, aluOp[2:0]} for the instruction class
  function automatic logic [3:0] alu_ctrl(input op_t op);
    case (op)
      OP_SUB:                     alu_ctrl = {1'b0, ALU_SUB};
      OP_AND:                     alu_ctrl = {1'b0, ALU_AND};
      OP_OR:                      alu_ctrl = {1'b0, ALU_OR};
      OP_ADDI, OP_LOAD, OP_STORE: alu_ctrl = {1'b1, ALU_ADD};
      OP_BEQ:                     alu_ctrl = {1'b0, ALU_SUB};
      default:                    alu_ctrl = {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Wrapping cycle and retired-instruction counters for the multi-cycle
// controller; only instantiated when MC_PERF_COUNT_EN is defined.
module mc_perf_counters #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_active,
  input  logic                   i_retire,
  output logic [COUNT_WIDTH-1:0] o_cycle_count,
  output logic [COUNT_WIDTH-1:0] o_retired_count
);

  // Counters wrap naturally at 2^COUNT_WIDTH
  always_ff @(posedge clk) begin
    if (rst) begin
      o_cycle_count   <= '0;
      o_retired_count <= '0;
    end else begin
      if (i_active) begin
        o_cycle_count <= o_cycle_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (i_retire) begin
        o_retired_count <= o_retired_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 20-bit-instruction datapath.
// Optional MC_PERF_COUNT_EN adds cycleCount/retiredCount performance counters.
module multicycle_controller #(
  parameter int OP_SIZE = mc_pkg::OP_SIZE
`ifdef MC_PERF_COUNT_EN
  , parameter int COUNT_WIDTH = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [OP_SIZE-1:0] opcode,
  input  logic               aluZero,
  input  logic               imemReady,
  input  logic               dmemReady,
  output logic               imemReq,
  output logic               dmemReq,
  output logic               dmemWe,
  output logic               irWrite,
  output logic               pcWrite,
  output logic [1:0]         pcSrc,
  output logic               aluSrcImm,
  output logic [2:0]         aluOp,
  output logic               regWrite,
  output logic [1:0]         wbSrc,
  output logic               retire,
  output logic               illegalOp,
  output logic               halted
`ifdef MC_PERF_COUNT_EN
  , output logic [COUNT_WIDTH-1:0] cycleCount,
  output logic [COUNT_WIDTH-1:0] retiredCount
`endif
);

  import mc_pkg::*;

  state_t             r_state;
  logic [OP_SIZE-1:0] r_op;
  logic [3:0]         w_alu;

  // State sequencing; the opcode is captured in DECODE and used from then on
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imemReady) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_op <= opcode;
          case (opcode)
            OP_JUMP, OP_NOP: r_state <= ST_FETCH;
            OP_HALT:         r_state <= ST_HALT;
            OP_LOADI:        r_state <= ST_WRITEBACK;
            default:         r_state <= op_is_legal(opcode) ? ST_EXECUTE : ST_FETCH;
          endcase
        end
        ST_EXECUTE: begin
          case (r_op)
            OP_LOAD, OP_STORE: r_state <= ST_MEMORY;
            OP_BEQ:            r_state <= ST_FETCH;
            default:           r_state <= ST_WRITEBACK;
          endcase
        end
        ST_MEMORY: begin
          if (dmemReady) r_state <= (r_op == OP_LOAD) ? ST_WRITEBACK : ST_FETCH;
        end
        ST_WRITEBACK: r_state <= ST_FETCH;
        ST_HALT:      r_state <= ST_HALT;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_alu = alu_ctrl(r_op);

  // Strobes decoded from state; ready inputs qualify completion-cycle strobes
  always_comb begin
    imemReq   = 1'b0;
    dmemReq   = 1'b0;
    dmemWe    = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    pcSrc     = PC_INC;
    aluSrcImm = 1'b0;
    aluOp     = ALU_ADD;
    regWrite  = 1'b0;
    wbSrc     = WB_ALU;
    retire    = 1'b0;
    illegalOp = 1'b0;
    halted    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imemReq = 1'b1;
        irWrite = imemReady;
        pcWrite = imemReady;
      end
      ST_DECODE: begin
        case (opcode)
          OP_JUMP: begin
            pcWrite = 1'b1;
            pcSrc   = PC_JUMP;
            retire  = 1'b1;
          end
          OP_NOP, OP_HALT: retire = 1'b1;
          default: begin
            if (op_is_legal(opcode)) illegalOp = 1'b0;
            else                     illegalOp = 1'b1;
          end
        endcase
      end
      ST_EXECUTE: begin
        {aluSrcImm, aluOp} = w_alu;
        if (r_op == OP_BEQ) begin
          pcWrite = aluZero;
          pcSrc   = PC_BRANCH;
          retire  = 1'b1;
        end else begin
          pcWrite = 1'b0;
        end
      end
      ST_MEMORY: begin
        {aluSrcImm, aluOp} = w_alu;
        dmemReq = 1'b1;
        dmemWe  = (r_op == OP_STORE);
        retire  = dmemReady && (r_op == OP_STORE);
      end
      ST_WRITEBACK: begin
        {aluSrcImm, aluOp} = w_alu;
        regWrite = 1'b1;
        retire   = 1'b1;
        case (r_op)
          OP_LOAD:  wbSrc = WB_MEM;
          OP_LOADI: wbSrc = WB_IMM;
          default:  wbSrc = WB_ALU;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

`ifdef MC_PERF_COUNT_EN
  logic w_active;
  assign w_active = (r_state != ST_IDLE) && (r_state != ST_HALT);

  mc_perf_counters #(.COUNT_WIDTH(COUNT_WIDTH)) u_perf (
    .clk             (clk),
    .rst             (rst),
    .i_active        (w_active),
    .i_retire        (retire),
    .o_cycle_count   (cycleCount),
    .o_retired_count (retiredCount)
  );
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected strobe vectors are
// queued as each cycle is driven and compared on the following falling edge.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst, run, aluZero, imemReady, dmemReady;
  logic [5:0] opcode;
  logic       imemReq, dmemReq, dmemWe, irWrite, pcWrite, aluSrcImm, regWrite;
  logic       retire, illegalOp, halted;
  logic [1:0] pcSrc, wbSrc;
  logic [2:0] aluOp;
`ifdef MC_PERF_COUNT_EN
  logic [31:0] cycleCount, retiredCount;
`endif

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] w_obs;

  localparam logic [16:0] E_IREQ   = 17'h10000;
  localparam logic [16:0] E_DREQ   = 17'h08000;
  localparam logic [16:0] E_DWE    = 17'h04000;
  localparam logic [16:0] E_IRW    = 17'h02000;
  localparam logic [16:0] E_PCW    = 17'h01000;
  localparam logic [16:0] E_PCS_J  = 17'h00800;
  localparam logic [16:0] E_PCS_BR = 17'h00400;
  localparam logic [16:0] E_IMM    = 17'h00200;
  localparam logic [16:0] E_AND    = 17'h00080;
  localparam logic [16:0] E_SUB    = 17'h00040;
  localparam logic [16:0] E_OR     = 17'h000C0;
  localparam logic [16:0] E_REGW   = 17'h00020;
  localparam logic [16:0] E_WB_IMM = 17'h00010;
  localparam logic [16:0] E_WB_MEM = 17'h00008;
  localparam logic [16:0] E_RET    = 17'h00004;
  localparam logic [16:0] E_ILL    = 17'h00002;
  localparam logic [16:0] E_HALT   = 17'h00001;
  localparam logic [16:0] E_NONE   = 17'h00000;

  assign w_obs = {imemReq, dmemReq, dmemWe, irWrite, pcWrite, pcSrc, aluSrcImm,
                  aluOp, regWrite, wbSrc, retire, illegalOp, halted};

  multicycle_controller dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .aluZero(aluZero),
    .imemReady(imemReady), .dmemReady(dmemReady), .imemReq(imemReq),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .irWrite(irWrite), .pcWrite(pcWrite),
    .pcSrc(pcSrc), .aluSrcImm(aluSrcImm), .aluOp(aluOp), .regWrite(regWrite),
    .wbSrc(wbSrc), .retire(retire), .illegalOp(illegalOp), .halted(halted)
`ifdef MC_PERF_COUNT_EN
    , .cycleCount(cycleCount), .retiredCount(retiredCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  // ALU control fields expected while an instruction is past DECODE
  function automatic logic [16:0] alu_exp(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ:             return E_SUB;
      OP_AND:                     return E_AND;
      OP_OR:                      return E_OR;
      OP_ADDI, OP_LOAD, OP_STORE: return E_IMM;
      default:                    return E_NONE;
    endcase
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic z,
                      input logic ir, input logic dr, input logic [16:0] exp,
                      input string tag);
    run = r; opcode = op; aluZero = z; imemReady = ir; dmemReady = dr;
    exp_q.push_back(exp);
    @(negedge clk);
    check_eq(tag, {15'd0, w_obs}, {15'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; opcode = 6'h00; aluZero = 1'b0;
    imemReady = 1'b0; dmemReady = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, rnd_op(), 1'b0, 1'b1, 1'b1, E_NONE, "reset_idle");
    step(1'b1, rnd_op(), 1'b0, 1'b1, 1'b1, E_NONE, "idle_run");
  endtask

  // One full instruction starting in FETCH; opcode only valid in DECODE
  task automatic do_instr(input logic [5:0] op, input logic z, input int iw, input int dw);
    logic [16:0] a;
    a = alu_exp(op);
    for (int i = 0; i < iw; i++) step(1'b1, rnd_op(), z, 1'b0, 1'b1, E_IREQ, "fetch_wait");
    step(1'b0, rnd_op(), z, 1'b1, 1'b1, E_IREQ | E_IRW | E_PCW, "fetch");
    case (op)
      OP_JUMP: step(1'b0, op, z, 1'b1, 1'b1, E_PCW | E_PCS_J | E_RET, "jump_decode");
      OP_NOP:  step(1'b0, op, z, 1'b1, 1'b1, E_RET, "nop_decode");
      OP_HALT: step(1'b0, op, z, 1'b1, 1'b1, E_RET, "halt_decode");
      OP_LOADI: begin
        step(1'b0, op, z, 1'b1, 1'b1, E_NONE, "loadi_decode");
        step(1'b0, rnd_op(), z, 1'b1, 1'b1, E_REGW | E_WB_IMM | E_RET, "loadi_wb");
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
        step(1'b0, op, z, 1'b1, 1'b1, E_NONE, "r_decode");
        step(1'b0, rnd_op(), z, 1'b1, 1'b1, a, "r_execute");
        step(1'b0, rnd_op(), z, 1'b1, 1'b1, a | E_REGW | E_RET, "r_wb");
      end
      OP_LOAD, OP_STORE: begin
        step(1'b0, op, z, 1'b1, 1'b1, E_NONE, "mem_decode");
        step(1'b0, rnd_op(), z, 1'b1, 1'b1, a, "mem_execute");
        if (op == OP_STORE) a = a | E_DWE;
        for (int i = 0; i < dw; i++) step(1'b0, rnd_op(), z, 1'b1, 1'b0, a | E_DREQ, "mem_wait");
        if (op == OP_STORE) begin
          step(1'b0, rnd_op(), z, 1'b1, 1'b1, a | E_DREQ | E_RET, "store_done");
        end else begin
          step(1'b0, rnd_op(), z, 1'b1, 1'b1, a | E_DREQ, "load_done");
          step(1'b0, rnd_op(), z, 1'b1, 1'b1, a | E_REGW | E_WB_MEM | E_RET, "load_wb");
        end
      end
      OP_BEQ: begin
        step(1'b0, op, z, 1'b1, 1'b1, E_NONE, "beq_decode");
        step(1'b0, rnd_op(), z, 1'b1, 1'b1, a | E_PCS_BR | (z ? E_PCW : E_NONE) | E_RET, "beq_execute");
      end
      default: step(1'b0, op, z, 1'b1, 1'b1, E_ILL, "illegal_decode");
    endcase
  endtask

  initial begin
    logic [16:0] st;
    do_reset();
    do_instr(OP_ADD, 1'b0, 0, 0);
    do_instr(OP_LOAD, 1'b0, 0, 3);
    do_instr(OP_BEQ, 1'b1, 0, 0);
    do_instr(OP_BEQ, 1'b0, 0, 0);
    do_instr(OP_SUB, 1'b0, 2, 0);
    do_instr(OP_AND, 1'b1, 0, 0);
    do_instr(OP_OR, 1'b0, 1, 0);
    do_instr(OP_ADDI, 1'b0, 0, 0);
    do_instr(OP_STORE, 1'b0, 0, 1);
    do_instr(OP_LOADI, 1'b0, 0, 0);
    do_instr(OP_NOP, 1'b0, 0, 0);
    do_instr(OP_JUMP, 1'b0, 0, 0);
    do_instr(6'h3A, 1'b0, 0, 0);
    do_instr(OP_ADD, 1'b0, 0, 0);
    do_instr(OP_HALT, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, rnd_op(), 1'(i), 1'b1, 1'b1, E_HALT, "halt_hold");

    // Reset while a STORE waits in MEMORY: request dropped, nothing retires
    do_reset();
    step(1'b0, rnd_op(), 1'b0, 1'b1, 1'b1, E_IREQ | E_IRW | E_PCW, "st_fetch");
    step(1'b0, OP_STORE, 1'b0, 1'b1, 1'b1, E_NONE, "st_decode");
    step(1'b0, rnd_op(), 1'b0, 1'b1, 1'b1, E_IMM, "st_execute");
    st = E_IMM | E_DREQ | E_DWE;
    step(1'b0, rnd_op(), 1'b0, 1'b1, 1'b0, st, "st_wait");
    rst = 1'b1;
    step(1'b0, rnd_op(), 1'b0, 1'b1, 1'b0, st, "st_rst_cycle");
    rst = 1'b0;
    step(1'b0, rnd_op(), 1'b0, 1'b1, 1'b1, E_NONE, "rst_mid_mem");
`ifdef MC_PERF_COUNT_EN
    check_eq("cycle_cnt_rst", cycleCount, 32'd0);
    check_eq("retired_cnt_rst", retiredCount, 32'd0);
`endif
    step(1'b0, rnd_op(), 1'b0, 1'b1, 1'b1, E_NONE, "idle_stays");

    // Counter scenario: JUMP, LOADI, HALT with zero wait states
    do_reset();
    do_instr(OP_JUMP, 1'b0, 0, 0);
    do_instr(OP_LOADI, 1'b0, 0, 0);
    do_instr(OP_HALT, 1'b0, 0, 0);
    step(1'b0, rnd_op(), 1'b0, 1'b1, 1'b1, E_HALT, "halt_after_perf");
`ifdef MC_PERF_COUNT_EN
    check_eq("cycle_cnt", cycleCount, 32'd7);
    check_eq("retired_cnt", retiredCount, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
